// File: rtl/pe_array_if_buf.sv
// pe_array_if_buf
//   Instruction-fetch stage for the PE array. Instructions arrive from IMEM
//   over a valid/ready handshake, are buffered in a small FIFO, and the head
//   instruction is pre-decoded (RF read addresses, bypass flags/selects,
//   immediate select) into registers facing ID. Handles ID stall, flush and
//   back-pressure toward IMEM.
//
// Ports
//   iClk, iReset               clock (posedge), synchronous active-high reset
//   iIMEM_Valid / oIMEM_Ready  IMEM handshake; ready depends on occupancy only
//   iIMEM_Instruction          fetched instruction
//   iPredication               predication bits, travel with the instruction
//   iData_Selection            data-selection bits, travel with the instruction
//   iID_Stall                  ID cannot consume the current output
//   iFlush                     drop everything buffered and in flight
//   oID_Valid                  output registers hold a live instruction
//   oIF_ID_Instruction         registered instruction (0 after flush/reset)
//   oPredication               registered predication
//   oIF_BP_Data_Selection      registered data selection
//   oIF_RF_Read_Addr_A/B       RF read addresses (held when operand bypassed)
//   oIF_BP_Bypass_Read_A/B     operand comes from the bypass network
//   oIF_BP_Bypass_Sel_A/B      bypass source (held when operand not bypassed)
//   oIF_BP_Select_Imm          second operand is the immediate (I-type)
//   oBuf_Count                 FIFO occupancy
module pe_array_if_buf #(
    parameter int INS_WIDTH = 24,
    parameter int RF_IDX_W  = 5,
    parameter int BP_SEL_W  = 2,
    parameter int SRC1_LSB  = 8,
    parameter int SRC2_LSB  = 3,
    parameter int TYPE_BIT  = 23,
    parameter int PRED_W    = 2,
    parameter int DSEL_W    = 2,
    parameter int BUF_DEPTH = 2
) (
    input  logic                         iClk,
    input  logic                         iReset,
    input  logic                         iIMEM_Valid,
    output logic                         oIMEM_Ready,
    input  logic [INS_WIDTH-1:0]         iIMEM_Instruction,
    input  logic [PRED_W-1:0]            iPredication,
    input  logic [DSEL_W-1:0]            iData_Selection,
    input  logic                         iID_Stall,
    input  logic                         iFlush,
    output logic                         oID_Valid,
    output logic [INS_WIDTH-1:0]         oIF_ID_Instruction,
    output logic [PRED_W-1:0]            oPredication,
    output logic [DSEL_W-1:0]            oIF_BP_Data_Selection,
    output logic [RF_IDX_W-1:0]          oIF_RF_Read_Addr_A,
    output logic [RF_IDX_W-1:0]          oIF_RF_Read_Addr_B,
    output logic                         oIF_BP_Bypass_Read_A,
    output logic                         oIF_BP_Bypass_Read_B,
    output logic [BP_SEL_W-1:0]          oIF_BP_Bypass_Sel_A,
    output logic [BP_SEL_W-1:0]          oIF_BP_Bypass_Sel_B,
    output logic                         oIF_BP_Select_Imm,
    output logic [$clog2(BUF_DEPTH):0]   oBuf_Count
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INS_WIDTH-1:0] insMem  [BUF_DEPTH];
    logic [PRED_W-1:0]    predMem [BUF_DEPTH];
    logic [DSEL_W-1:0]    dselMem [BUF_DEPTH];
    logic [PTR_W-1:0]     wrPtr;
    logic [PTR_W-1:0]     rdPtr;

    logic                 push;
    logic                 load;
    logic                 haveHead;
    logic                 pop;
    logic                 wrFifo;
    logic                 srcValid;
    logic [INS_WIDTH-1:0] srcIns;
    logic [PRED_W-1:0]    srcPred;
    logic [DSEL_W-1:0]    srcDsel;
    logic [RF_IDX_W-1:0]  srcA;
    logic [RF_IDX_W-1:0]  srcB;
    logic                 bypA;
    logic                 bypB;

    assign oIMEM_Ready = (oBuf_Count != CNT_W'(BUF_DEPTH));

    always_comb begin
        push     = iIMEM_Valid & oIMEM_Ready;
        load     = ~oID_Valid | ~iID_Stall;
        haveHead = (oBuf_Count != '0);
        pop      = load & haveHead;
        // An incoming instruction bypasses the FIFO only when the FIFO is
        // empty and the output register is taking a new value this cycle.
        wrFifo   = push & ~(load & ~haveHead);
        srcValid = haveHead | push;

        srcIns  = iIMEM_Instruction;
        srcPred = iPredication;
        srcDsel = iData_Selection;
        if (haveHead) begin
            srcIns  = insMem[rdPtr];
            srcPred = predMem[rdPtr];
            srcDsel = dselMem[rdPtr];
        end

        srcA = srcIns[SRC1_LSB +: RF_IDX_W];
        srcB = srcIns[SRC2_LSB +: RF_IDX_W];
        bypA = &srcIns[SRC1_LSB+RF_IDX_W-1 : SRC1_LSB+BP_SEL_W];
        bypB = &srcIns[SRC2_LSB+RF_IDX_W-1 : SRC2_LSB+BP_SEL_W];
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                insMem[i]  <= '0;
                predMem[i] <= '0;
                dselMem[i] <= '0;
            end
            wrPtr                 <= '0;
            rdPtr                 <= '0;
            oBuf_Count            <= '0;
            oID_Valid             <= 1'b0;
            oIF_ID_Instruction    <= '0;
            oPredication          <= '0;
            oIF_BP_Data_Selection <= '0;
            oIF_RF_Read_Addr_A    <= '0;
            oIF_RF_Read_Addr_B    <= '0;
            oIF_BP_Bypass_Read_A  <= 1'b0;
            oIF_BP_Bypass_Read_B  <= 1'b0;
            oIF_BP_Bypass_Sel_A   <= '0;
            oIF_BP_Bypass_Sel_B   <= '0;
            oIF_BP_Select_Imm     <= 1'b0;
        end else if (iFlush) begin
            // Decode registers deliberately keep their values; only the
            // instruction is forced to a NOP.
            wrPtr              <= '0;
            rdPtr              <= '0;
            oBuf_Count         <= '0;
            oID_Valid          <= 1'b0;
            oIF_ID_Instruction <= '0;
        end else begin
            if (wrFifo) begin
                insMem[wrPtr]  <= iIMEM_Instruction;
                predMem[wrPtr] <= iPredication;
                dselMem[wrPtr] <= iData_Selection;
                wrPtr          <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({wrFifo, pop})
                2'b10:   oBuf_Count <= oBuf_Count + CNT_W'(1);
                2'b01:   oBuf_Count <= oBuf_Count - CNT_W'(1);
                default: oBuf_Count <= oBuf_Count;
            endcase

            if (load) begin
                oID_Valid <= srcValid;
                if (srcValid) begin
                    oIF_ID_Instruction    <= srcIns;
                    oPredication          <= srcPred;
                    oIF_BP_Data_Selection <= srcDsel;
                    oIF_BP_Bypass_Read_A  <= bypA;
                    oIF_BP_Bypass_Read_B  <= bypB;
                    oIF_BP_Select_Imm     <= srcIns[TYPE_BIT];
                    if (bypA) oIF_BP_Bypass_Sel_A <= srcA[BP_SEL_W-1:0];
                    else      oIF_RF_Read_Addr_A  <= srcA;
                    if (bypB) oIF_BP_Bypass_Sel_B <= srcB[BP_SEL_W-1:0];
                    else      oIF_RF_Read_Addr_B  <= srcB;
                end
            end
        end
    end

endmodule
